// File: rtl/seq_scan_ctrl_pkg.sv
// Shared types and defaults for the serial pattern-scan controller.
package seq_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    REPORT = 2'd2
  } state_t;

  localparam int DEF_WORD_W = 16;
  localparam int DEF_PAT_W  = 4;
  localparam int COUNT_W    = 5;

endpackage

// File: rtl/seq_scan_ctrl_pattern_window.sv
// Sliding window over the serial bit stream: shift register, fill counter
// and match flag for the bit currently being shifted in.
module pattern_window
  import seq_scan_ctrl_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             bit_in,
  input  logic [PAT_W-1:0] pattern,
  input  logic             overlap,
  output logic             match
);

  localparam int CNT_W = $clog2(PAT_W + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(PAT_W);

  logic [PAT_W-1:0] window_q;
  logic [PAT_W-1:0] window_d;
  logic [CNT_W-1:0] vcnt_q;
  logic [CNT_W-1:0] vcnt_d;

  // Match is judged on the window including the incoming bit, so it fires
  // in the same cycle the completing bit arrives.
  always_comb begin
    window_d = (window_q << 1) | PAT_W'(bit_in);
    vcnt_d   = (vcnt_q == FULL) ? FULL : vcnt_q + 1'b1;
    match    = shift_en && (vcnt_d == FULL) && (window_d == pattern);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      window_q <= '0;
      vcnt_q   <= '0;
    end else if (clear) begin
      window_q <= '0;
      vcnt_q   <= '0;
    end else if (shift_en) begin
      window_q <= window_d;
      vcnt_q   <= (match && !overlap) ? '0 : vcnt_d;
    end
  end

endmodule

// File: rtl/seq_scan_ctrl.sv
// Accepts a word plus pattern, scans it MSB first one bit per cycle and
// reports the match count and completion mask with a valid/ready handshake.
//
//   state  | meaning
//   IDLE   | ready for a word; accept latches word/pattern/mode
//   SHIFT  | one bit per cycle, WORD_W cycles, index counts down to 0
//   REPORT | result held; out_valid one cycle after entry until taken
module seq_scan_ctrl
  import seq_scan_ctrl_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W,
  parameter int PAT_W  = DEF_PAT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WORD_W-1:0]   in_word,
  input  logic [PAT_W-1:0]    in_pattern,
  input  logic                in_overlap,
  input  logic                abort,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [COUNT_W-1:0]  out_count,
  output logic [WORD_W-1:0]   out_mask
);

  localparam int IDX_W = $clog2(WORD_W);

  state_t               state_q;
  state_t               state_d;
  logic [WORD_W-1:0]    word_q;
  logic [WORD_W-1:0]    mask_q;
  logic [PAT_W-1:0]     pattern_q;
  logic                 overlap_q;
  logic [IDX_W-1:0]     idx_q;
  logic [COUNT_W-1:0]   count_q;
  logic                 valid_q;
  logic                 accept;
  logic                 shift_en;
  logic                 flush;
  logic                 match;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    accept   = 1'b0;
    shift_en = 1'b0;
    flush    = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = !rst;
        accept   = in_valid;
        if (in_valid) state_d = SHIFT;
      end
      SHIFT: begin
        flush    = abort;
        shift_en = !abort;
        if (abort)           state_d = IDLE;
        else if (idx_q == '0) state_d = REPORT;
      end
      REPORT: begin
        flush = abort;
        if (abort)                      state_d = IDLE;
        else if (valid_q && out_ready)  state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // out_valid is registered off "staying in REPORT", so it lags REPORT
  // entry by one cycle and drops on the handshake or abort edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q    <= '0;
      pattern_q <= '0;
      overlap_q <= 1'b0;
      idx_q     <= '0;
      count_q   <= '0;
      mask_q    <= '0;
      valid_q   <= 1'b0;
    end else begin
      valid_q <= (state_q == REPORT) && (state_d == REPORT);
      if (accept) begin
        word_q    <= in_word;
        pattern_q <= in_pattern;
        overlap_q <= in_overlap;
        idx_q     <= IDX_W'(WORD_W - 1);
        count_q   <= '0;
        mask_q    <= '0;
      end else if (flush) begin
        count_q <= '0;
        mask_q  <= '0;
      end else if (shift_en) begin
        idx_q <= idx_q - 1'b1;
        if (match) begin
          count_q       <= count_q + 1'b1;
          mask_q[idx_q] <= 1'b1;
        end
      end
    end
  end

  pattern_window #(.PAT_W(PAT_W)) u_window (
    .clk      (clk),
    .rst      (rst),
    .clear    (accept),
    .shift_en (shift_en),
    .bit_in   (word_q[idx_q]),
    .pattern  (pattern_q),
    .overlap  (overlap_q),
    .match    (match)
  );

  assign out_valid = valid_q;
  assign out_count = count_q;
  assign out_mask  = mask_q;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Scoreboard bench for seq_scan_ctrl: directed words with hand-computed
// results; a negedge monitor pops and compares on each output handshake.
module tb_seq_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_word;
  logic [3:0]  in_pattern;
  logic        in_overlap;
  logic        abort;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_count;
  logic [15:0] out_mask;

  typedef struct packed {
    logic [4:0]  cnt;
    logic [15:0] mask;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;

  seq_scan_ctrl #(.WORD_W(16), .PAT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_word    (in_word),
    .in_pattern (in_pattern),
    .in_overlap (in_overlap),
    .abort      (abort),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_count  (out_count),
    .out_mask   (out_mask)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready && !abort) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("result_count", 32'(out_count), 32'(mon_e.cnt));
        check("result_mask", 32'(out_mask), 32'(mon_e.mask));
      end
    end
  end

  // Offer one word, measure accept-to-valid latency, then either drain it
  // (optionally after backpressure) or abort it while out_ready is high.
  task automatic do_word(input logic [15:0] w, input logic [3:0] p, input logic ov,
                         input logic [4:0] ec, input logic [15:0] em,
                         input int hold, input bit abort_in_report);
    exp_t e;
    int   lat;
    in_word    = w;
    in_pattern = p;
    in_overlap = ov;
    in_valid   = 1'b1;
    out_ready  = (hold == 0 && !abort_in_report);
    if (!abort_in_report) begin
      e.cnt  = ec;
      e.mask = em;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = c;
        break;
      end
    end
    check("latency", 32'(lat), 32'd17);
    if (abort_in_report) begin
      check("report_count", 32'(out_count), 32'(ec));
      abort     = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      check("abort_prio", 32'({out_valid, in_ready}), 32'b01);
      return;
    end
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        check("bp_stable", 32'({out_valid, in_ready, out_count, out_mask}),
              32'({1'b1, 1'b0, ec, em}));
      end
      out_ready = 1'b1;
      #1;
      check("bp_in_ready_low", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    check("post_handshake", 32'({out_valid, in_ready}), 32'b01);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw;
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_word    = '0;
    in_pattern = '0;
    in_overlap = 1'b0;
    abort      = 1'b0;
    out_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 32'({in_ready, out_valid, out_count, out_mask}), 32'd0);
    rst = 1'b0;
    #1;
    check("ready_after_reset", 32'(in_ready), 32'd1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_idle_ignored", 32'({in_ready, out_valid}), 32'b10);

    do_word(16'h5555, 4'b0101, 1'b1, 5'd7,  16'h1555, 0, 1'b0);
    do_word(16'h5555, 4'b0101, 1'b0, 5'd4,  16'h1111, 0, 1'b0);
    do_word(16'h0000, 4'b0000, 1'b1, 5'd13, 16'h1FFF, 0, 1'b0);
    do_word(16'h6666, 4'b0110, 1'b1, 5'd4,  16'h1111, 0, 1'b0);
    do_word(16'h5555, 4'b0101, 1'b1, 5'd7,  16'h1555, 5, 1'b0);

    // Abort during the eighth SHIFT cycle of a word that would match often.
    in_word = 16'h0000; in_pattern = 4'b0000; in_overlap = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_shift_idle", 32'({in_ready, out_valid}), 32'b10);
    saw = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (out_valid) saw = 1'b1;
    end
    check("abort_no_valid", 32'(saw), 32'd0);
    do_word(16'h5555, 4'b0101, 1'b1, 5'd7, 16'h1555, 0, 1'b0);

    // Reset pulse mid-SHIFT, after the first match has been counted.
    in_word = 16'h5555; in_pattern = 4'b0101; in_overlap = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rst_mid_shift", 32'({in_ready, out_valid, out_count, out_mask}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("ready_after_rst", 32'(in_ready), 32'd1);
    do_word(16'h0000, 4'b0000, 1'b0, 5'd4, 16'h1111, 0, 1'b0);

    // Abort and out_ready together in REPORT: abort wins, no result.
    do_word(16'h6666, 4'b0110, 1'b0, 5'd4, 16'h1111, 0, 1'b1);
    do_word(16'h5555, 4'b0101, 1'b0, 5'd4, 16'h1111, 0, 1'b0);

    repeat (3) @(posedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_scan_ctrl.md
SEQ_SCAN_CTRL -- requirements
Module: seq_scan_ctrl

Interface
REQ-001 SHALL have parameter WORD_W, default 16, the scanned word width.
REQ-002 SHALL have parameter PAT_W, default 4, the pattern length.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  word and configuration offered.
REQ-006 SHALL have port in_ready  output  1  controller accepts a word.
REQ-007 SHALL have port in_word  input  WORD_W  word to scan, MSB first.
REQ-008 SHALL have port in_pattern  input  PAT_W  pattern to detect, first-received bit in the MSB.
REQ-009 SHALL have port in_overlap  input  1  1 = overlapping matches, 0 = non-overlapping.
REQ-010 SHALL have port abort  input  1  synchronous abort of the current scan.
REQ-011 SHALL have port out_valid  output  1  result available.
REQ-012 SHALL have port out_ready  input  1  consumer takes the result.
REQ-013 SHALL have port out_count  output  5  number of matches in the word.
REQ-014 SHALL have port out_mask  output  WORD_W  bit i set = a match completed on word bit i.

Function
REQ-015 SHALL implement the states IDLE, SHIFT and REPORT.
REQ-016 IDLE: in_ready=1; in_valid=1 latches in_word, in_pattern and in_overlap, clears the detector window, count and mask, and moves to SHIFT.
REQ-017 SHIFT: one bit per cycle, MSB first; exactly WORD_W cycles; in_ready=0.
REQ-018 A match SHALL be flagged on the cycle the bit completing it is shifted in, when at least PAT_W bits are valid in the window and the window equals the latched pattern.
REQ-019 On a match, count SHALL increment and mask bit i SHALL set (i = index of the completing bit).
REQ-020 In non-overlap mode, the window valid-bit counter SHALL reset to 0 after a match; in overlap mode it SHALL saturate at PAT_W.
REQ-021 The window SHALL NOT carry history across words.
REQ-022 After the last SHIFT cycle, the controller SHALL enter REPORT; out_valid SHALL rise exactly WORD_W+1 cycles after the accept edge.
REQ-023 REPORT: out_valid=1; out_count and out_mask SHALL stay stable until out_valid and out_ready are both 1 on the same cycle, then return to IDLE.
REQ-024 A new word SHALL NOT be accepted in the REPORT-to-IDLE transition cycle (no bypass); in_ready rises the cycle after the handshake.
REQ-025 abort=1 in SHIFT or REPORT SHALL return to IDLE next cycle with out_valid=0 and no result; abort SHALL be ignored in IDLE.
REQ-026 abort has priority over out_ready when both occur in REPORT.
REQ-027 The count width of 5 bits SHALL hold the maximum of WORD_W-PAT_W+1 = 13 at the default parameters without wrap.

Reset
REQ-028 rst=1 SHALL force, immediately, state=IDLE, in_ready=1 after release, out_valid=0, out_count=0, out_mask=0, and a cleared window and latched configuration.
REQ-029 Reset mid-SHIFT or mid-REPORT SHALL discard the in-flight word; no result is emitted.

Structure
REQ-030 The shared package SHALL hold the state enum (IDLE, SHIFT, REPORT) and the default WORD_W/PAT_W constants.
REQ-031 The window compare SHALL be a sub-module pattern_window (shift register, valid-bit counter, match flag), instantiated once.

Verification
REQ-032 Overlap: pattern 0101, word 0x5555 -> out_count=7, out_mask=0x1555, out_valid at accept+17.
REQ-033 Non-overlap: pattern 0101, word 0x5555 -> out_count=4, out_mask=0x1111.
REQ-034 Boundary: pattern 0000, word 0x0000, overlap -> out_count=13, out_mask=0x1FFF; pattern 0110, word 0x6666 -> out_count=4, out_mask=0x1111.
REQ-035 Backpressure: hold out_ready=0 for 5 cycles in REPORT -> outputs stable; in_ready stays 0 until the cycle after the handshake.
REQ-036 abort at SHIFT cycle 8 -> IDLE next cycle, no out_valid; the next word 0x5555 (overlap) gives count 7 with no leakage from the aborted word.
REQ-037 rst pulse mid-SHIFT -> all outputs 0 immediately; the next word scans correctly.
